// File: rtl/rec_pkg.sv
// Shared types and constants for the recording scheduler: FSM state encoding
// (also driven out on o_state for display) and default memory geometry.
package rec_pkg;

  localparam int unsigned SMP_W      = 16;
  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned MAX_ADDR_DEF = (1 << ADDR_W_DEF) - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REC   = 3'd1,
    S_PAUSE = 3'd2,
    S_DRAIN = 3'd3,
    S_FULL  = 3'd4
  } rec_state_e;

endpackage

// File: rtl/rec_scheduler_if.sv
// Sample-memory write port: one word per req/ack handshake; request, address
// and data are held stable by the master until the slave acks.
interface rec_scheduler_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/rec_peak_tracker.sv
// Running peak of |sample| over accepted samples, for the level visualizer.
// The peak sags by one LSB every 256 accepted samples so it slowly follows the signal down.
module rec_peak_tracker #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                     i_BCLK,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_vld,
  input  logic signed [DATA_W-1:0] i_smp,
  output logic        [DATA_W-1:0] o_peak
);

  // Two's-complement magnitude; the most negative code has no positive twin and saturates.
  function automatic logic [DATA_W-1:0] sat_abs(input logic signed [DATA_W-1:0] s);
    logic signed [DATA_W-1:0] neg;
    if (s == {1'b1, {(DATA_W-1){1'b0}}}) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (s < 0) begin
      neg = -s;
      return $unsigned(neg);
    end else begin
      return $unsigned(s);
    end
  endfunction

  logic [DATA_W-1:0] mag_p0;
  logic [DATA_W-1:0] max_p0;
  logic [7:0]        cnt_q;

  assign mag_p0 = sat_abs(i_smp);
  assign max_p0 = (mag_p0 > o_peak) ? mag_p0 : o_peak;

  // p0 -> p1: fold the accepted sample into the peak register
  always_ff @(posedge i_BCLK) begin
    if (i_rst || i_clr) begin
      o_peak <= '0;
      cnt_q  <= '0;
    end else if (i_vld) begin
      cnt_q <= cnt_q + 8'd1;
      if (cnt_q == 8'hFF && max_p0 != '0) begin
        o_peak <= max_p0 - 1'b1;
      end else begin
        o_peak <= max_p0;
      end
    end
  end

endmodule

// File: rtl/rec_scheduler.sv
// Audio capture sequencer: arms the ADC, turns each done edge into one memory
// write at an incrementing address. Define REC_PEAK_EN to add the o_peak level output.
module rec_scheduler
  import rec_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic                    i_BCLK,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_pause,
  input  logic                    i_stop,
  output logic                    o_record,
  input  logic signed [SMP_W-1:0] i_adc_data,
  input  logic                    i_adc_done,
  rec_scheduler_if.master         mem,
  output logic [ADDR_W-1:0]       o_end_addr,
  output logic [2:0]              o_state,
  output logic                    o_full,
  output logic                    o_overrun
`ifdef REC_PEAK_EN
  ,
  output logic [SMP_W-1:0]        o_peak
`endif
);

  rec_state_e        state, state_nxt;
  logic              restart_q, restart_nxt;
  logic              rec_clr;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic              edge_p0;
  logic              accept_p0;
  logic              ack_p0;
  logic              last_ack;

  assign edge_p0   = i_adc_done & ~done_q;
  assign accept_p0 = edge_p0 && (state == S_REC) && !mem.wr_req;
  assign ack_p0    = mem.wr_req && mem.wr_ack;
  assign last_ack  = ack_p0 && (mem.wr_addr == MAX_ADDR);

  assign o_record = (state == S_REC);
  assign o_state  = state;

  always_ff @(posedge i_BCLK) begin
    if (i_rst) begin
      state     <= S_IDLE;
      restart_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      restart_q <= restart_nxt;
    end
  end

  // A start while recording is remembered in restart_q and honoured once the drain finishes.
  always_comb begin
    state_nxt   = state;
    restart_nxt = restart_q;
    rec_clr     = 1'b0;
    unique case (state)
      S_IDLE, S_FULL: begin
        if (i_start) begin
          state_nxt   = S_REC;
          restart_nxt = 1'b0;
          rec_clr     = 1'b1;
        end
      end
      S_REC, S_PAUSE: begin
        if (last_ack) begin
          state_nxt = S_FULL;
        end else if (i_stop) begin
          state_nxt   = S_DRAIN;
          restart_nxt = 1'b0;
        end else if (i_start) begin
          state_nxt   = S_DRAIN;
          restart_nxt = 1'b1;
        end else if (i_pause) begin
          state_nxt = (state == S_REC) ? S_PAUSE : S_REC;
        end
      end
      S_DRAIN: begin
        if (i_stop) begin
          restart_nxt = 1'b0;
        end else if (i_start) begin
          restart_nxt = 1'b1;
        end
        if (!mem.wr_req || mem.wr_ack) begin
          if (restart_nxt) begin
            state_nxt   = S_REC;
            restart_nxt = 1'b0;
            rec_clr     = 1'b1;
          end else if (last_ack) begin
            state_nxt = S_FULL;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        restart_nxt = 1'b0;
      end
    endcase
  end

  // p0 -> p1: done edge latched into the write port, handshake retired on ack.
  // The counter saturates on the final word, so o_end_addr tops out at MAX_ADDR with o_full set.
  always_ff @(posedge i_BCLK) begin
    if (i_rst) begin
      done_q      <= 1'b0;
      mem.wr_req  <= 1'b0;
      mem.wr_addr <= '0;
      mem.wr_data <= '0;
      addr_q      <= '0;
      o_end_addr  <= '0;
      o_full      <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      done_q <= i_adc_done;
      if (accept_p0) begin
        mem.wr_req  <= 1'b1;
        mem.wr_addr <= addr_q;
        mem.wr_data <= i_adc_data;
      end else if (ack_p0) begin
        mem.wr_req <= 1'b0;
      end
      if (rec_clr) begin
        addr_q     <= '0;
        o_end_addr <= '0;
        o_full     <= 1'b0;
        o_overrun  <= 1'b0;
      end else begin
        if (ack_p0 && !last_ack) begin
          addr_q     <= addr_q + 1'b1;
          o_end_addr <= o_end_addr + 1'b1;
        end
        if (last_ack) begin
          o_full <= 1'b1;
        end
        if (edge_p0 && (state == S_REC) && mem.wr_req) begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

`ifdef REC_PEAK_EN
  rec_peak_tracker #(
    .DATA_W (SMP_W)
  ) u_peak (
    .i_BCLK (i_BCLK),
    .i_rst  (i_rst),
    .i_clr  (rec_clr),
    .i_vld  (accept_p0),
    .i_smp  (i_adc_data),
    .o_peak (o_peak)
  );
`endif

endmodule

// File: tb/tb_rec_scheduler.sv
// Scenario bench for rec_scheduler with a small address space so the full
// condition is reachable; a memory responder collects every acked write.
module tb_rec_scheduler;
  import rec_pkg::*;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_p = 1'b0, pause_p = 1'b0, stop_p = 1'b0;
  logic        record;
  logic [15:0] adc_data = '0;
  logic        adc_done = 1'b0;
  logic [AW-1:0] end_addr;
  logic [2:0]  state;
  logic        full, overrun;
`ifdef REC_PEAK_EN
  logic [15:0] peak;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int ack_delay = 2;
  bit ack_hold  = 1'b0;
  bit stray_ack = 1'b0;
  int wait_cnt  = 0;

  logic [AW-1:0] got_a[$];
  logic [15:0]   got_d[$];
  logic [AW-1:0] exp_a[$];
  logic [15:0]   exp_d[$];

  always #5 clk = ~clk;

  rec_scheduler_if #(.ADDR_W(AW)) mem ();

  rec_scheduler #(.ADDR_W(AW)) dut (
    .i_BCLK     (clk),
    .i_rst      (rst),
    .i_start    (start_p),
    .i_pause    (pause_p),
    .i_stop     (stop_p),
    .o_record   (record),
    .i_adc_data (adc_data),
    .i_adc_done (adc_done),
    .mem        (mem),
    .o_end_addr (end_addr),
    .o_state    (state),
    .o_full     (full),
    .o_overrun  (overrun)
`ifdef REC_PEAK_EN
    ,
    .o_peak     (peak)
`endif
  );

  // Memory side: acks each request after ack_delay idle cycles unless held.
  initial begin
    mem.wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      mem.wr_ack = 1'b0;
      if (stray_ack) begin
        mem.wr_ack = 1'b1;
      end else if (mem.wr_req === 1'b1 && !ack_hold) begin
        if (wait_cnt >= ack_delay) begin
          mem.wr_ack = 1'b1;
          got_a.push_back(mem.wr_addr);
          got_d.push_back(mem.wr_data);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic p, input logic t);
    @(negedge clk);
    start_p = s; pause_p = p; stop_p = t;
    @(negedge clk);
    start_p = 1'b0; pause_p = 1'b0; stop_p = 1'b0;
  endtask

  task automatic send_sample(input logic [15:0] d);
    @(negedge clk);
    adc_data = d;
    adc_done = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    adc_done = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while (mem.wr_req === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (mem.wr_req !== 1'b0) begin
      n_err++;
      $display("FAIL settle: wr_req=%b, required 0 within 200 cycles", mem.wr_req);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start_p = 1'b0; pause_p = 1'b0; stop_p = 1'b0;
    adc_done = 1'b0; ack_hold = 1'b0; stray_ack = 1'b0;
    tick(3);
    rst = 1'b0;
    got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    ack_hold = 1'b1;
    send_sample(16'hA5A5);
    n_cmp++;
    if (mem.wr_req !== 1'b1) begin n_err++; $display("FAIL pre_reset_req: got %b, required 1", mem.wr_req); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem.wr_req, record, full, overrun} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: req/rec/full/ovr=%b, required 0000", {mem.wr_req, record, full, overrun});
    end
    n_cmp++;
    if (state !== 3'd0 || end_addr !== '0) begin
      n_err++; $display("FAIL reset_state: state=%0d end_addr=%0d, required 0/0", state, end_addr);
    end
    n_cmp++;
    if (mem.wr_addr !== '0 || mem.wr_data !== 16'h0) begin
      n_err++; $display("FAIL reset_bus: addr=%0d data=%h, required 0/0000", mem.wr_addr, mem.wr_data);
    end
    ack_hold = 1'b0;
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_capture();
    logic [15:0] pat [4];
    pat = '{16'h1234, 16'h8000, 16'h7FFF, 16'h0001};
    do_reset();
    ack_delay = 2;
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (state !== 3'd1 || record !== 1'b1) begin
      n_err++; $display("FAIL start_rec: state=%0d record=%b, required 1/1", state, record);
    end
    for (int i = 0; i < 4; i++) begin
      send_sample(pat[i]);
      settle();
      exp_a.push_back(AW'(i)); exp_d.push_back(pat[i]);
    end
    stray_ack = 1'b1;
    tick(1);
    stray_ack = 1'b0;
    tick(2);
    n_cmp++;
    if (got_a.size() != exp_a.size()) begin
      n_err++; $display("FAIL capture_count: got %0d writes, required %0d", got_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        n_cmp++;
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
          n_err++; $display("FAIL capture_wr%0d: got %0d:%h, required %0d:%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
        end
      end
    end
    n_cmp++;
    if (end_addr !== AW'(4) || record !== 1'b1 || overrun !== 1'b0) begin
      n_err++; $display("FAIL capture_end: end_addr=%0d record=%b overrun=%b, required 4/1/0", end_addr, record, overrun);
    end
  endtask

  task automatic test_pause();
    logic [15:0] d [6];
    for (int i = 0; i < 6; i++) d[i] = 16'($urandom);
    do_reset();
    ack_delay = $urandom_range(1, 3);
    pulse(1'b1, 1'b0, 1'b0);
    send_sample(d[0]); settle();
    exp_a.push_back(AW'(0)); exp_d.push_back(d[0]);
    send_sample(d[1]);
    pulse(1'b0, 1'b1, 1'b0);
    exp_a.push_back(AW'(1)); exp_d.push_back(d[1]);
    n_cmp++;
    if (state !== 3'd2 || record !== 1'b0) begin
      n_err++; $display("FAIL pause_enter: state=%0d record=%b, required 2/0", state, record);
    end
    settle();
    for (int i = 2; i < 5; i++) begin
      send_sample(d[i]); settle();
    end
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (state !== 3'd1 || record !== 1'b1) begin
      n_err++; $display("FAIL pause_resume: state=%0d record=%b, required 1/1", state, record);
    end
    send_sample(d[5]); settle();
    exp_a.push_back(AW'(2)); exp_d.push_back(d[5]);
    n_cmp++;
    if (got_a.size() != 3) begin
      n_err++; $display("FAIL pause_count: got %0d writes, required 3", got_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
          n_err++; $display("FAIL pause_wr%0d: got %0d:%h, required %0d:%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
        end
      end
    end
    n_cmp++;
    if (end_addr !== AW'(3) || overrun !== 1'b0) begin
      n_err++; $display("FAIL pause_end: end_addr=%0d overrun=%b, required 3/0", end_addr, overrun);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] a, b, c;
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
    do_reset();
    ack_delay = 2;
    pulse(1'b1, 1'b0, 1'b0);
    ack_hold = 1'b1;
    send_sample(a);
    tick(3);
    send_sample(b);
    tick(30);
    n_cmp++;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_flag: got %b, required 1", overrun); end
    n_cmp++;
    if (mem.wr_req !== 1'b1 || mem.wr_addr !== '0 || mem.wr_data !== a) begin
      n_err++; $display("FAIL overrun_hold: req=%b addr=%0d data=%h, required 1/0/%h", mem.wr_req, mem.wr_addr, mem.wr_data, a);
    end
    ack_hold = 1'b0;
    settle();
    send_sample(c); settle();
    n_cmp++;
    if (got_a.size() != 2) begin
      n_err++; $display("FAIL overrun_count: got %0d writes, required 2", got_a.size());
    end else begin
      n_cmp++;
      if (got_a[0] !== AW'(0) || got_d[0] !== a || got_a[1] !== AW'(1) || got_d[1] !== c) begin
        n_err++; $display("FAIL overrun_wr: got %0d:%h %0d:%h, required 0:%h 1:%h", got_a[0], got_d[0], got_a[1], got_d[1], a, c);
      end
    end
    n_cmp++;
    if (end_addr !== AW'(2) || overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_end: end_addr=%0d overrun=%b, required 2/1", end_addr, overrun);
    end
  endtask

  task automatic test_full();
    logic [15:0] d;
    int words;
    words = 1 << AW;
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < words; i++) begin
      ack_delay = $urandom_range(0, 3);
      d = 16'($urandom);
      send_sample(d); settle();
      exp_a.push_back(AW'(i)); exp_d.push_back(d);
      if (i == words - 2) begin
        n_cmp++;
        if (full !== 1'b0 || state !== 3'd1) begin
          n_err++; $display("FAIL full_early: full=%b state=%0d, required 0/1", full, state);
        end
      end
    end
    n_cmp++;
    if (full !== 1'b1 || state !== 3'd4 || record !== 1'b0) begin
      n_err++; $display("FAIL full_set: full=%b state=%0d record=%b, required 1/4/0", full, state, record);
    end
    n_cmp++;
    if (end_addr !== AW'(words - 1)) begin
      n_err++; $display("FAIL full_end_addr: got %0d, required %0d", end_addr, words - 1);
    end
    send_sample(16'h5555); settle();
    send_sample(16'hAAAA); settle();
    n_cmp++;
    if (got_a.size() != words) begin
      n_err++; $display("FAIL full_count: got %0d writes, required %0d", got_a.size(), words);
    end else begin
      for (int i = 0; i < words; i++) begin
        n_cmp++;
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
          n_err++; $display("FAIL full_wr%0d: got %0d:%h, required %0d:%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
        end
      end
    end
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (state !== 3'd1 || full !== 1'b0 || end_addr !== '0) begin
      n_err++; $display("FAIL full_restart: state=%0d full=%b end_addr=%0d, required 1/0/0", state, full, end_addr);
    end
    d = 16'($urandom);
    send_sample(d); settle();
    n_cmp++;
    if (got_a.size() == 0 || got_a[$] !== '0 || got_d[$] !== d) begin
      n_err++; $display("FAIL full_restart_wr: last write %0d:%h, required 0:%h", got_a[$], got_d[$], d);
    end
  endtask

  task automatic test_stop_drain();
    logic [15:0] a;
    int n;
    a = 16'($urandom);
    do_reset();
    ack_delay = 1;
    pulse(1'b1, 1'b0, 1'b0);
    ack_hold = 1'b1;
    send_sample(a);
    pulse(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (state !== 3'd3 || record !== 1'b0) begin
      n_err++; $display("FAIL drain_enter: state=%0d record=%b, required 3/0", state, record);
    end
    tick(5);
    n_cmp++;
    if (state !== 3'd3) begin n_err++; $display("FAIL drain_wait: state=%0d, required 3", state); end
    ack_hold = 1'b0;
    n = 0;
    while (state !== 3'd0 && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (state !== 3'd0 || end_addr !== AW'(1) || got_a.size() != 1) begin
      n_err++; $display("FAIL drain_exit: state=%0d end_addr=%0d writes=%0d, required 0/1/1", state, end_addr, got_a.size());
    end else begin
      n_cmp++;
      if (got_a[0] !== '0 || got_d[0] !== a) begin
        n_err++; $display("FAIL drain_wr: got %0d:%h, required 0:%h", got_a[0], got_d[0], a);
      end
    end
  endtask

  task automatic test_start_stop_priority();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (state !== 3'd3) begin n_err++; $display("FAIL prio_drain: state=%0d, required 3", state); end
    tick(2);
    n_cmp++;
    if (state !== 3'd0 || record !== 1'b0) begin
      n_err++; $display("FAIL prio_stop_wins: state=%0d record=%b, required 0/0", state, record);
    end
  endtask

  task automatic test_restart();
    logic [15:0] b, c;
    int n;
    b = 16'($urandom); c = 16'($urandom);
    do_reset();
    ack_delay = 2;
    pulse(1'b1, 1'b0, 1'b0);
    send_sample(16'($urandom)); settle();
    ack_hold = 1'b1;
    send_sample(b);
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (state !== 3'd3) begin n_err++; $display("FAIL restart_drain: state=%0d, required 3", state); end
    ack_hold = 1'b0;
    n = 0;
    while (state !== 3'd1 && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (state !== 3'd1 || end_addr !== '0 || got_a.size() != 2) begin
      n_err++; $display("FAIL restart_rec: state=%0d end_addr=%0d writes=%0d, required 1/0/2", state, end_addr, got_a.size());
    end
    send_sample(c); settle();
    n_cmp++;
    if (got_a.size() != 3 || got_a[$] !== '0 || got_d[$] !== c || end_addr !== AW'(1)) begin
      n_err++; $display("FAIL restart_wr: last %0d:%h end_addr=%0d, required 0:%h end_addr 1", got_a[$], got_d[$], end_addr, c);
    end
  endtask

`ifdef REC_PEAK_EN
  task automatic test_peak();
    logic [15:0] smp [6];
    int model, v;
    smp[0] = 16'hFED4; smp[1] = 16'd5000; smp[2] = 16'h8000;
    for (int i = 3; i < 6; i++) smp[i] = 16'($urandom);
    do_reset();
    ack_delay = 1;
    pulse(1'b1, 1'b0, 1'b0);
    model = 0;
    for (int i = 0; i < 6; i++) begin
      send_sample(smp[i]); settle();
      v = int'($signed(smp[i]));
      if (v < 0) v = -v;
      if (v > 32767) v = 32767;
      if (v > model) model = v;
      n_cmp++;
      if (peak !== 16'(model)) begin
        n_err++; $display("FAIL peak%0d: got %0d, required %0d", i, peak, model);
      end
    end
    pulse(1'b0, 1'b0, 1'b1);
    tick(2);
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (peak !== 16'd0) begin n_err++; $display("FAIL peak_clear: got %0d, required 0", peak); end
  endtask
`endif

  initial begin
    test_reset();
    test_capture();
    test_pause();
    test_overrun();
    test_full();
    test_stop_drain();
    test_start_stop_priority();
    test_restart();
`ifdef REC_PEAK_EN
    test_peak();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
